// File: rtl/pam_demod_pkg.sv
// Shared types and helpers for the PAM demodulator carrier-recovery path.
package pam_demod_pkg;

  localparam int PHASE_W = 9;

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } loop_mode_t;

  // Symmetric saturation to +-(2^(w-1)-1); caller narrows the result to w bits.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned      w);
    logic signed [63:0] lim;
    lim = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

endpackage

// File: rtl/pam_lock_detect.sv
// Carrier lock detector: counts good/bad phase-error samples and selects ACQUIRE/TRACK.
// State and counters advance on the edge after a valid sample; mode is registered.
module pam_lock_detect
  import pam_demod_pkg::*;
#(
  parameter int LOCK_THRESH   = 16,
  parameter int LOCK_COUNT    = 255,
  parameter int UNLOCK_THRESH = 64,
  parameter int UNLOCK_COUNT  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sample_vld,
  input  logic [PHASE_W-1:0] phi_error,
  output loop_mode_t         mode,
  output logic               locked
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);

  localparam logic [PHASE_W:0]  LOCK_T    = (PHASE_W + 1)'(LOCK_THRESH);
  localparam logic [PHASE_W:0]  UNLOCK_T  = (PHASE_W + 1)'(UNLOCK_THRESH);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_COUNT - 1);

  loop_mode_t        state_q, state_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [BAD_W-1:0]  bad_cnt_q, bad_cnt_d;

  // One extra bit so that |-256| = 256 is representable.
  logic [PHASE_W:0] e_ext;
  logic [PHASE_W:0] abs_e;

  assign e_ext = {phi_error[PHASE_W-1], phi_error};
  assign abs_e = e_ext[PHASE_W] ? (~e_ext + 1'b1) : e_ext;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ACQUIRE;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (sample_vld) begin
      unique case (state_q)
        ACQUIRE: begin
          if (abs_e < LOCK_T) begin
            if (good_cnt_q == GOOD_LAST) begin
              state_d    = TRACK;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else begin
            good_cnt_d = '0;
          end
        end
        TRACK: begin
          if (abs_e >= UNLOCK_T) begin
            if (bad_cnt_q == BAD_LAST) begin
              state_d   = ACQUIRE;
              bad_cnt_d = '0;
            end else begin
              bad_cnt_d = bad_cnt_q + 1'b1;
            end
          end else begin
            bad_cnt_d = '0;
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  always_comb begin
    mode   = state_q;
    locked = (state_q == TRACK);
  end

endmodule

// File: rtl/pam_phase_loop.sv
// Carrier-phase PI loop filter + NCO; one update per valid phase error.
// Outputs reflect a sample one edge after it is presented; no backpressure.
module pam_phase_loop
  import pam_demod_pkg::*;
#(
  parameter int FRAC          = 8,
  parameter int INT_W         = 20,
  parameter int KP_SHIFT_ACQ  = 2,
  parameter int KI_SHIFT_ACQ  = 6,
  parameter int KP_SHIFT_TRK  = 4,
  parameter int KI_SHIFT_TRK  = 10,
  parameter int LOCK_THRESH   = 16,
  parameter int LOCK_COUNT    = 255,
  parameter int UNLOCK_THRESH = 64,
  parameter int UNLOCK_COUNT  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PHASE_W-1:0]      phi_error,
  input  logic                    err_valid,
  input  logic                    loop_clear,
  output logic [PHASE_W-1:0]      phase_acum_mod,
  output logic                    phase_valid,
  output logic signed [INT_W-1:0] freq_word,
  output logic                    locked
);

  localparam int ACC_W = PHASE_W + FRAC;

  loop_mode_t mode;

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic                    phase_valid_q, phase_valid_d;

  logic signed [INT_W-1:0] e_f;
  logic signed [INT_W-1:0] prop;
  logic signed [INT_W-1:0] ki_term;
  logic signed [INT_W:0]   integ_sum;
  logic signed [INT_W-1:0] integ_new;
  logic [ACC_W-1:0]        acc_new;

  // A sample dropped by loop_clear must not advance the lock counters either.
  pam_lock_detect #(
    .LOCK_THRESH  (LOCK_THRESH),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_THRESH(UNLOCK_THRESH),
    .UNLOCK_COUNT (UNLOCK_COUNT)
  ) u_lock (
    .clk       (clk),
    .reset_n   (reset_n),
    .sample_vld(err_valid & ~loop_clear),
    .phi_error (phi_error),
    .mode      (mode),
    .locked    (locked)
  );

  assign e_f = $signed({{(INT_W - ACC_W){phi_error[PHASE_W-1]}}, phi_error, {FRAC{1'b0}}});

  // Gains follow the registered mode, so a transition sample uses the old gains.
  assign prop    = (mode == TRACK) ? (e_f >>> KP_SHIFT_TRK) : (e_f >>> KP_SHIFT_ACQ);
  assign ki_term = (mode == TRACK) ? (e_f >>> KI_SHIFT_TRK) : (e_f >>> KI_SHIFT_ACQ);

  assign integ_sum = $signed({integ_q[INT_W-1], integ_q}) + $signed({ki_term[INT_W-1], ki_term});
  assign integ_new = INT_W'(sat_signed(64'(integ_sum), INT_W));

  // Summed at INT_W then truncated: the low ACC_W bits give the wrapped phase.
  assign acc_new = ACC_W'({{(INT_W - ACC_W){1'b0}}, acc_q} + integ_new + prop);

  always_comb begin
    acc_d         = acc_q;
    integ_d       = integ_q;
    phase_valid_d = 1'b0;
    if (loop_clear) begin
      acc_d   = '0;
      integ_d = '0;
    end else if (err_valid) begin
      acc_d         = acc_new;
      integ_d       = integ_new;
      phase_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q         <= '0;
      integ_q       <= '0;
      phase_valid_q <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      integ_q       <= integ_d;
      phase_valid_q <= phase_valid_d;
    end
  end

  assign phase_acum_mod = acc_q[ACC_W-1:FRAC];
  assign freq_word      = integ_q;
  assign phase_valid    = phase_valid_q;

endmodule

// File: tb/tb_pam_phase_loop.sv
// Randomized bench for pam_phase_loop against an integer-arithmetic loop model.
module tb_pam_phase_loop;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [8:0]        phi_error;
  logic              err_valid;
  logic              loop_clear;
  logic [8:0]        phase_acum_mod;
  logic              phase_valid;
  logic signed [19:0] freq_word;
  logic              locked;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_acc, m_integ, m_good, m_bad;
  bit m_track, m_pv;

  pam_phase_loop dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .phi_error     (phi_error),
    .err_valid     (err_valid),
    .loop_clear    (loop_clear),
    .phase_acum_mod(phase_acum_mod),
    .phase_valid   (phase_valid),
    .freq_word     (freq_word),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_integ = 0; m_good = 0; m_bad = 0; m_track = 0; m_pv = 0;
  endtask

  task automatic model_update(input bit v, input int e, input bit c);
    int ef, kp, ki, mag;
    if (c) begin
      m_acc = 0; m_integ = 0; m_pv = 0;
    end else if (v) begin
      ef = e * 256;
      kp = m_track ? 4 : 2;
      ki = m_track ? 10 : 6;
      m_integ = m_integ + (ef >>> ki);
      if (m_integ > 524287) m_integ = 524287;
      if (m_integ < -524287) m_integ = -524287;
      m_acc = (m_acc + m_integ + (ef >>> kp)) % 131072;
      if (m_acc < 0) m_acc += 131072;
      m_pv = 1;
      mag = (e < 0) ? -e : e;
      if (!m_track) begin
        if (mag < 16) begin
          m_good++;
          if (m_good == 255) begin m_track = 1; m_good = 0; end
        end else m_good = 0;
      end else begin
        if (mag >= 64) begin
          m_bad++;
          if (m_bad == 32) begin m_track = 0; m_bad = 0; end
        end else m_bad = 0;
      end
    end else begin
      m_pv = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".phase"}, phase_acum_mod, m_acc / 256);
    chk({tag, ".freq"}, $signed(freq_word), m_integ);
    chk({tag, ".locked"}, locked, m_track);
    chk({tag, ".pvld"}, phase_valid, m_pv);
  endtask

  task automatic step(input bit v, input int e, input bit c);
    @(negedge clk);
    err_valid  = v;
    phi_error  = 9'(e);
    loop_clear = c;
    @(posedge clk);
    #1;
    model_update(v, e, c);
    compare_all("step");
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_phase"}, phase_acum_mod, 0);
    chk({tag, ".rst_freq"}, $signed(freq_word), 0);
    chk({tag, ".rst_locked"}, locked, 0);
    chk({tag, ".rst_pvld"}, phase_valid, 0);
    err_valid = 1'b0; loop_clear = 1'b0; phi_error = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; err_valid = 1'b0; loop_clear = 1'b0; phi_error = '0;
    model_reset();
    #1;
    compare_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // First update from reset: e=+16 in ACQUIRE
    step(1, 16, 0);
    chk("first.freq", $signed(freq_word), 64);
    chk("first.phase", phase_acum_mod, 4);
    chk("first.pvld", phase_valid, 1);

    // Integrator saturation with a large constant error
    step(0, 0, 1);
    repeat (600) step(1, 255, 0);
    chk("sat.freq", $signed(freq_word), 524287);
    step(1, 255, 0);
    chk("sat.hold", $signed(freq_word), 524287);

    // Lock acquisition then loss, with one good sample restarting the bad count
    step(0, 0, 1);
    repeat (254) step(1, 0, 0);
    chk("lock.pre", locked, 0);
    step(1, 0, 0);
    chk("lock.rise", locked, 1);
    repeat (30) step(1, 100, 0);
    step(1, 0, 0);
    repeat (31) step(1, 100, 0);
    chk("unlock.restart", locked, 1);
    step(1, 100, 0);
    chk("unlock.fall", locked, 0);

    // -256 in TRACK: proportional path uses the tracking shift
    step(0, 0, 1);
    repeat (255) step(1, 0, 0);
    step(0, 0, 1);
    step(1, -256, 0);
    chk("neg.freq", $signed(freq_word), -64);
    chk("neg.phase", phase_acum_mod, 495);
    chk("neg.locked", locked, 1);

    // Clear wins over a coincident valid; gaps hold the outputs
    step(1, 50, 0);
    step(1, 50, 1);
    chk("clr.phase", phase_acum_mod, 0);
    chk("clr.freq", $signed(freq_word), 0);
    chk("clr.pvld", phase_valid, 0);
    chk("clr.locked", locked, 1);
    step(1, 37, 0);
    repeat (4) step(0, 200, 0);

    // Randomized bursts alternating small and large errors
    for (int b = 0; b < 8; b++) begin
      if (b == 4) async_reset("mid");
      for (int k = 0; k < 300; k++) begin
        bit v, c;
        int e;
        v = ($urandom_range(0, 9) < 8);
        c = ($urandom_range(0, 99) == 0);
        if (b % 2 == 0) e = int'($urandom_range(0, 30)) - 15;
        else            e = int'($urandom_range(0, 511)) - 256;
        step(v, e, c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
